paula_floppy_serializer: RTL and testbench
==========================================

PAULA_FLOPPY_SERIALIZER -- requirements
Module: paula_floppy_serializer

Interface
REQ-001 SHALL have parameter BITCELL, default 14, meaning clk7_en ticks per MFM bit cell (2 us at 7.09 MHz); legal range 2..31.
REQ-002 SHALL have parameter FILL_WORD, default 16'hAAAA, meaning the word transmitted on FIFO underrun.
REQ-003 SHALL have ports:
- clk  input  1  bus clock
- reset  input  1  synchronous, active-high reset, sampled only when clk7_en=1
- clk7_en  input  1  clock enable; all state advances only when 1
- start  input  1  one-cycle pulse; begins transfer of len words
- len  input  14  word count, latched on start
- fifo_data  input  16  FIFO output word
- fifo_empty  input  1  FIFO empty flag
- fifo_rd  output  1  FIFO pop request
- bit_out  output  1  serial MFM data, MSB first
- bit_strobe  output  1  pulse in the first tick of each bit cell
- busy  output  1  transfer in progress
- done  output  1  one-tick pulse when the final word's last bit cell ends
- underrun  output  1  one-tick pulse when FILL_WORD is substituted
- sync_match  output  1  sync detect pulse (see Configuration)
- dsksync  input  16  sync pattern

Function
REQ-004 SHALL implement states IDLE, SHIFT. Word fetch runs as an independent prefetch engine.
REQ-005 Prefetch: one 16-bit holding register plus hold_valid and a settle flag.
REQ-006 Prefetch SHALL pop only when busy, !hold_valid, !fifo_empty and !settle, and only while words remain unfetched: fifo_rd=1 for one tick, hold<=fifo_data, hold_valid<=1, settle<=1.
REQ-007 settle SHALL clear on the following tick. fifo_data/fifo_empty are ignored while settle=1, because the FIFO's output and empty flag lag its read pointer by one tick.
REQ-008 IDLE: bit_out=0, busy=0. On start with len!=0: latch len into a 14-bit remaining counter, busy<=1, go SHIFT with the word boundary pending. Start with len==0: done pulses next tick, stay IDLE.
REQ-009 SHIFT: the bit counter (4 bits) and tick counter (5 bits) run. bit_strobe=1 when tick counter==0.
REQ-010 At tick counter==BITCELL-1, the tick counter wraps to 0 and the shift register shifts left.
REQ-011 Word boundary is bit 15 end, or entry to SHIFT. Action depends on remaining:
- remaining!=0 and hold_valid: shreg<=hold, hold_valid<=0, remaining-=1.
- remaining!=0 and !hold_valid: shreg<=FILL_WORD, underrun pulse, remaining-=1.
- remaining==0: done pulse, busy<=0, go IDLE.
REQ-012 Output is continuous: no idle tick between words when hold_valid.
REQ-013 Boundary load has priority over a prefetch pop in the same tick; a pop may occur on the next tick.
REQ-014 start while busy SHALL be ignored.
REQ-015 bit_out SHALL equal shreg[15] while in SHIFT.
REQ-016 Total words popped SHALL never exceed the latched len. Underrun words count toward len.

Reset
REQ-017 On reset (with clk7_en=1), mid-transfer or otherwise, all registers SHALL clear:
- state=IDLE
- busy=0, done=0, underrun=0, fifo_rd=0, bit_out=0, bit_strobe=0, sync_match=0
- hold_valid=0, settle=0, all counters 0
REQ-018 Reset SHALL take priority over start on the same tick.

Configuration
REQ-019 With macro PAULA_FLOPPY_SYNC_EN defined: a 16-bit history register captures each transmitted bit at cell end. sync_match pulses one tick when history==dsksync. The history register clears on start and reset.
REQ-020 Without PAULA_FLOPPY_SYNC_EN: sync_match SHALL be constant 0 and the history register is not implemented.

Verification
REQ-021 FIFO holds 16'h4489,16'h5555; start len=2, BITCELL=14 -> bit_out stream 0100010010001001 then 0101010101010101, each bit 14 ticks wide, no gap; 2 fifo_rd pulses; done 448 ticks after first bit_strobe.
REQ-022 FIFO empty; start len=3 -> three FILL_WORD words (1010...), 3 underrun pulses, 0 fifo_rd, then done.
REQ-023 FIFO gets a word mid-transfer (len=2, first word present, second written after 100 ticks) -> word 2 sent normally, no underrun.
REQ-024 Reset asserted at bit 7 of word 1 -> next tick: busy=0, bit_out=0, fifo_rd=0; a later start with len=1 behaves as from power-up.
REQ-025 PAULA_FLOPPY_SYNC_EN defined, dsksync=16'h4489, FIFO 16'hAAAA,16'h4489 -> exactly one sync_match, at the last bit cell of word 2. Without the macro, sync_match stays 0.
REQ-026 start with len=0 -> done pulse one tick later, no fifo_rd, busy stays 0. start pulsed while busy -> ignored, word count unchanged.

Source files
------------

// File: rtl/paula_floppy_serializer.sv
// -----------------------------------------------------------------------------
// paula_floppy_serializer
//
// Floppy write-path serializer. Words taken from a FIFO are shifted out MSB
// first as MFM bit cells, each BITCELL clk7_en ticks wide. A single-word
// prefetch register sits between the FIFO and the shifter, so consecutive
// words leave without a gap. If the prefetch register is still empty when a
// new word is needed, FILL_WORD is sent in its place and counts toward len.
//
// Parameters
//   BITCELL    clk7_en ticks per bit cell (2..31, default 14 = 2 us @ 7.09 MHz)
//   FILL_WORD  word sent on FIFO underrun (default 16'hAAAA)
//
// Ports
//   clk         bus clock
//   reset       synchronous active-high reset, honoured only when clk7_en=1
//   clk7_en     clock enable; no state moves while it is low
//   start       one-tick pulse, begins a transfer of len words (ignored if busy)
//   len         word count, latched on start
//   fifo_data   FIFO head word
//   fifo_empty  FIFO empty flag
//   fifo_rd     FIFO pop request (one tick per word)
//   bit_out     serial MFM data, MSB first
//   bit_strobe  high during the first tick of every bit cell
//   busy        transfer in progress
//   done        one-tick pulse after the last bit cell of the last word
//   underrun    one-tick pulse when FILL_WORD replaces a missing FIFO word
//   sync_match  one-tick pulse when the last 16 sent bits equal dsksync
//   dsksync     sync pattern
//
// Build option
//   PAULA_FLOPPY_SYNC_EN  when defined, a 16-bit history of transmitted bits is
//                         kept and compared against dsksync at every cell end.
//                         When undefined, sync_match is tied to 0.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module paula_floppy_serializer #(
  parameter int unsigned BITCELL   = 14,
  parameter logic [15:0] FILL_WORD = 16'hAAAA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic        start,
  input  logic [13:0] len,
  input  logic [15:0] fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_rd,
  output logic        bit_out,
  output logic        bit_strobe,
  output logic        busy,
  output logic        done,
  output logic        underrun,
  output logic        sync_match,
  input  logic [15:0] dsksync
);

  localparam logic [4:0] TICK_LAST = 5'(BITCELL - 1);

  // Lead-in after start: one tick lets the prefetch engine fetch the first
  // word, the next tick performs the entry word boundary (load or fill).
  localparam logic [1:0] LEAD_FETCH = 2'd2;
  localparam logic [1:0] LEAD_LOAD  = 2'd1;
  localparam logic [1:0] LEAD_NONE  = 2'd0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t      state_q,      state_d;
  logic        busy_q,       busy_d;
  logic        done_q,       done_d;
  logic        underrun_q,   underrun_d;
  logic [13:0] remaining_q,  remaining_d;
  logic [15:0] shreg_q,      shreg_d;
  logic [15:0] hold_q,       hold_d;
  logic        hold_valid_q, hold_valid_d;
  logic        settle_q,     settle_d;
  logic [3:0]  bit_cnt_q,    bit_cnt_d;
  logic [4:0]  tick_cnt_q,   tick_cnt_d;
  logic [1:0]  lead_q,       lead_d;
`ifdef PAULA_FLOPPY_SYNC_EN
  logic [15:0] hist_q,       hist_d;
`endif

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  logic in_shift;
  logic cell_end;
  logic word_end;
  logic boundary;
  logic pop;

  assign in_shift = (state_q == ST_SHIFT);
  assign cell_end = in_shift && (lead_q == LEAD_NONE) && (tick_cnt_q == TICK_LAST);
  assign word_end = cell_end && (bit_cnt_q == 4'd15);
  assign boundary = in_shift && ((lead_q == LEAD_LOAD) || word_end);

  // A word is only fetched while some of len is still unloaded. Since the
  // holding register must be empty to fetch, "remaining != 0" already means
  // at least one word is unfetched. The FIFO flags are stale for one tick
  // after a pop, hence the settle qualifier. A boundary load wins over a pop.
  assign pop = busy_q && !hold_valid_q && !fifo_empty && !settle_q &&
               (remaining_q != 14'd0) && !boundary;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    underrun_d   = 1'b0;
    remaining_d  = remaining_q;
    shreg_d      = shreg_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    settle_d     = 1'b0;
    bit_cnt_d    = bit_cnt_q;
    tick_cnt_d   = tick_cnt_q;
    lead_d       = lead_q;
`ifdef PAULA_FLOPPY_SYNC_EN
    hist_d       = hist_q;
`endif

    // Prefetch engine, independent of the shifter state.
    if (pop) begin
      hold_d       = fifo_data;
      hold_valid_d = 1'b1;
      settle_d     = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef PAULA_FLOPPY_SYNC_EN
          hist_d = 16'h0000;
`endif
          if (len != 14'd0) begin
            remaining_d = len;
            busy_d      = 1'b1;
            state_d     = ST_SHIFT;
            lead_d      = LEAD_FETCH;
            shreg_d     = 16'h0000;
            bit_cnt_d   = 4'd0;
            tick_cnt_d  = 5'd0;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      ST_SHIFT: begin
        if (lead_q == LEAD_FETCH) begin
          lead_d = LEAD_LOAD;
        end else if (lead_q == LEAD_LOAD) begin
          lead_d = LEAD_NONE;
        end else if (cell_end) begin
          tick_cnt_d = 5'd0;
          bit_cnt_d  = bit_cnt_q + 4'd1;   // wraps 15 -> 0 at the word end
          shreg_d    = {shreg_q[14:0], 1'b0};
`ifdef PAULA_FLOPPY_SYNC_EN
          hist_d     = {hist_q[14:0], shreg_q[15]};
`endif
        end else begin
          tick_cnt_d = tick_cnt_q + 5'd1;
        end

        // Word boundary overrides the plain shift computed above.
        if (boundary) begin
          if (remaining_q != 14'd0) begin
            remaining_d = remaining_q - 14'd1;
            if (hold_valid_q) begin
              shreg_d      = hold_q;
              hold_valid_d = 1'b0;
            end else begin
              shreg_d    = FILL_WORD;
              underrun_d = 1'b1;
            end
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clk7_en) begin
      if (reset) begin
        // NOTE: the shift and holding registers are datapath, but they are
        // cleared too so bit_out and any later load start from a known value.
        state_q      <= ST_IDLE;
        busy_q       <= 1'b0;
        done_q       <= 1'b0;
        underrun_q   <= 1'b0;
        remaining_q  <= 14'd0;
        shreg_q      <= 16'h0000;
        hold_q       <= 16'h0000;
        hold_valid_q <= 1'b0;
        settle_q     <= 1'b0;
        bit_cnt_q    <= 4'd0;
        tick_cnt_q   <= 5'd0;
        lead_q       <= LEAD_NONE;
`ifdef PAULA_FLOPPY_SYNC_EN
        hist_q       <= 16'h0000;
`endif
      end else begin
        state_q      <= state_d;
        busy_q       <= busy_d;
        done_q       <= done_d;
        underrun_q   <= underrun_d;
        remaining_q  <= remaining_d;
        shreg_q      <= shreg_d;
        hold_q       <= hold_d;
        hold_valid_q <= hold_valid_d;
        settle_q     <= settle_d;
        bit_cnt_q    <= bit_cnt_d;
        tick_cnt_q   <= tick_cnt_d;
        lead_q       <= lead_d;
`ifdef PAULA_FLOPPY_SYNC_EN
        hist_q       <= hist_d;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy       = busy_q;
  assign done       = done_q;
  assign underrun   = underrun_q;
  assign bit_out    = in_shift ? shreg_q[15] : 1'b0;
  assign bit_strobe = in_shift && (lead_q == LEAD_NONE) && (tick_cnt_q == 5'd0);

  // Pop is a single-tick event, so it is qualified with the enable and is
  // suppressed while reset is being applied.
  assign fifo_rd = clk7_en && !reset && pop;

`ifdef PAULA_FLOPPY_SYNC_EN
  // Compared during the last tick of each cell, including the bit being sent.
  assign sync_match = clk7_en && !reset && cell_end &&
                      ({hist_q[14:0], shreg_q[15]} == dsksync);
`else
  logic unused_dsksync;
  assign unused_dsksync = ^dsksync;
  assign sync_match     = 1'b0;
`endif

endmodule

// File: tb/tb_paula_floppy_serializer.sv
// -----------------------------------------------------------------------------
// tb_paula_floppy_serializer
//
// Self-checking bench. A lagging FIFO model feeds the DUT; for each transfer
// the expected bit stream is queued when the transfer is launched and popped
// at every bit_strobe. Per-transfer counts (pops, underruns, done, sync) and
// timing come from a table of vectors; reset, len=0 and enable stalls are
// exercised by hand-written sequences.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_paula_floppy_serializer;

  localparam int          BC   = 14;
  localparam logic [15:0] FILL = 16'hAAAA;
`ifdef PAULA_FLOPPY_SYNC_EN
  localparam int SYNC_ON = 1;
`else
  localparam int SYNC_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        clk7_en;
  logic        start;
  logic [13:0] len;
  logic [15:0] fifo_data  = 16'h0000;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd;
  logic        bit_out;
  logic        bit_strobe;
  logic        busy;
  logic        done;
  logic        underrun;
  logic        sync_match;
  logic [15:0] dsksync;

  paula_floppy_serializer #(
    .BITCELL   (BC),
    .FILL_WORD (FILL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clk7_en    (clk7_en),
    .start      (start),
    .len        (len),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .bit_out    (bit_out),
    .bit_strobe (bit_strobe),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun),
    .sync_match (sync_match),
    .dsksync    (dsksync)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // FIFO model: head word and empty flag lag the read pointer by one tick.
  // ---------------------------------------------------------------------------
  logic [15:0] mem [256];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  logic        fifo_flush = 1'b0;
  int          rd_cnt    = 0;
  int          pop_empty = 0;

  always @(posedge clk) begin
    if (clk7_en) begin
      fifo_data  <= mem[rd_ptr];
      fifo_empty <= (rd_ptr == wr_ptr);
      if (fifo_flush) begin
        rd_ptr <= wr_ptr;
      end else if (fifo_rd) begin
        rd_cnt <= rd_cnt + 1;
        if (rd_ptr == wr_ptr) pop_empty <= pop_empty + 1;
        else                  rd_ptr    <= rd_ptr + 8'd1;
      end
    end
  end

  task automatic push_word(input logic [15:0] w);
    mem[wr_ptr] = w;
    wr_ptr      = wr_ptr + 8'd1;
  endtask

  // ---------------------------------------------------------------------------
  // Checking and monitoring
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  bit exp_bits [$];
  bit cur_bit;
  bit cur_valid = 1'b0;
  int tick_no = 0;
  int ur_cnt, done_cnt, sync_cnt, strobe_cnt;
  int first_strobe, done_tick, sync_tick;

  // One clock; outputs are sampled 1 ns after the edge when the tick was enabled.
  task automatic tick();
    logic en;
    en = clk7_en;
    @(posedge clk);
    #1;
    if (en) begin
      tick_no++;
      if (underrun === 1'b1) ur_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        done_tick = tick_no;
        cur_valid = 1'b0;
      end
      if (sync_match === 1'b1) begin
        sync_cnt++;
        sync_tick = tick_no;
      end
      if (bit_strobe === 1'b1) begin
        strobe_cnt++;
        if (first_strobe < 0) first_strobe = tick_no;
        if (exp_bits.size() == 0) begin
          check("unexpected_bit_strobe", 32'(strobe_cnt), 32'(0));
        end else begin
          cur_bit   = exp_bits.pop_front();
          cur_valid = 1'b1;
          check("bit_first_tick", 32'(bit_out), 32'(cur_bit));
        end
      end else if (cur_valid && busy === 1'b1) begin
        check("bit_held", 32'(bit_out), 32'(cur_bit));
      end
    end
  endtask

  task automatic clear_stats();
    ur_cnt = 0; done_cnt = 0; sync_cnt = 0; strobe_cnt = 0;
    first_strobe = -1; done_tick = -1; sync_tick = -1;
  endtask

  task automatic flush_fifo();
    exp_bits.delete();
    cur_valid  = 1'b0;
    fifo_flush = 1'b1;
    tick();
    fifo_flush = 1'b0;
    tick();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    int          len;
    int          n0;          // words in the FIFO before start
    logic [15:0] w0, w1, w2;
    int          late_at;     // >0: push word n0 this many ticks after start
    int          restart_at;  // >0: pulse start (len=5) while busy
    int          stall_at;    // >0: drop clk7_en for 7 clocks
    int          exp_rd;
    int          exp_ur;
    int          exp_sync;
    int          sync_bits;   // bit cells until the sync pulse's cell ends
  } vec_t;

  vec_t vecs [8];

  function automatic logic [15:0] word_of(input vec_t v, input int i);
    case (i)
      0:       return v.w0;
      1:       return v.w1;
      default: return v.w2;
    endcase
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int          n_avail, budget, rd0, pe0, k;
    logic [15:0] w;
    logic        b0;
    n_avail = v.n0 + ((v.late_at > 0) ? 1 : 0);
    rd0 = rd_cnt;
    pe0 = pop_empty;
    clear_stats();
    for (int i = 0; i < v.n0; i++) push_word(word_of(v, i));
    for (int i = 0; i < v.len; i++) begin
      w = (i < n_avail) ? word_of(v, i) : FILL;
      for (int b = 15; b >= 0; b--) exp_bits.push_back(w[b]);
    end
    tick();
    len   = 14'(v.len);
    start = 1'b1;
    tick();
    start = 1'b0;
    len   = 14'h3FFF;  // must have been latched already
    budget = v.len * 16 * BC + 64;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      if (v.late_at > 0 && k == v.late_at) push_word(word_of(v, v.n0));
      if (v.restart_at > 0 && k == v.restart_at) begin
        len   = 14'd5;
        start = 1'b1;
      end
      if (v.stall_at > 0 && k == v.stall_at) begin
        b0 = bit_out;
        clk7_en = 1'b0;
        repeat (7) tick();
        check($sformatf("vec%0d_stall_bit", id), 32'(bit_out), 32'(b0));
        check($sformatf("vec%0d_stall_busy", id), 32'(busy), 32'(1));
        clk7_en = 1'b1;
      end
      tick();
      start = 1'b0;
      k++;
    end
    check($sformatf("vec%0d_done_seen", id), 32'(done_cnt), 32'(1));
    check($sformatf("vec%0d_busy_after", id), 32'(busy), 32'(0));
    check($sformatf("vec%0d_span", id), 32'(done_tick - first_strobe), 32'(v.len * 16 * BC));
    check($sformatf("vec%0d_fifo_rd", id), 32'(rd_cnt - rd0), 32'(v.exp_rd));
    check($sformatf("vec%0d_underrun", id), 32'(ur_cnt), 32'(v.exp_ur));
    check($sformatf("vec%0d_sync", id), 32'(sync_cnt), 32'(v.exp_sync));
    check($sformatf("vec%0d_bits_left", id), 32'(exp_bits.size()), 32'(0));
    check($sformatf("vec%0d_pop_empty", id), 32'(pop_empty - pe0), 32'(0));
    if (sync_cnt != 0)
      check($sformatf("vec%0d_sync_at", id), 32'(sync_tick - first_strobe), 32'(v.sync_bits * BC - 1));
    tick();
    check($sformatf("vec%0d_done_width", id), 32'(done), 32'(0));
    flush_fifo();
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int   rd0, k;
    vec_t pv;

    //          len n0  w0        w1        w2        late rst stall rd ur sync     bits
    vecs[0] = '{2,  2,  16'h4489, 16'h5555, 16'h0000, 0,   0,  0,    2, 0, SYNC_ON, 16};
    vecs[1] = '{3,  0,  16'h0000, 16'h0000, 16'h0000, 0,   0,  0,    0, 3, 0,       0};
    vecs[2] = '{2,  1,  16'h1111, 16'h2222, 16'h0000, 100, 0,  0,    2, 0, 0,       0};
    vecs[3] = '{1,  1,  16'h1234, 16'h0000, 16'h0000, 0,   0,  30,   1, 0, 0,       0};
    vecs[4] = '{3,  1,  16'hF00F, 16'h0000, 16'h0000, 0,   0,  0,    1, 2, 0,       0};
    vecs[5] = '{2,  3,  16'h0001, 16'h8000, 16'h7FFE, 0,   0,  0,    2, 0, 0,       0};
    vecs[6] = '{2,  2,  16'hAAAA, 16'h4489, 16'h0000, 0,   0,  0,    2, 0, SYNC_ON, 32};
    vecs[7] = '{2,  2,  16'h3C3C, 16'hC3C3, 16'h0000, 0,   50, 0,    2, 0, 0,       0};

    reset   = 1'b1;
    clk7_en = 1'b1;
    start   = 1'b0;
    len     = 14'd0;
    dsksync = 16'h4489;
    clear_stats();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_busy",       32'(busy),       32'(0));
    check("rst_bit_out",    32'(bit_out),    32'(0));
    check("rst_fifo_rd",    32'(fifo_rd),    32'(0));
    check("rst_done",       32'(done),       32'(0));
    check("rst_underrun",   32'(underrun),   32'(0));
    check("rst_bit_strobe", 32'(bit_strobe), 32'(0));
    check("rst_sync",       32'(sync_match), 32'(0));

    // len == 0: done one tick later, nothing else.
    rd0 = rd_cnt;
    len   = 14'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("len0_done",  32'(done), 32'(1));
    check("len0_busy",  32'(busy), 32'(0));
    tick();
    check("len0_done_width", 32'(done), 32'(0));
    check("len0_busy_later", 32'(busy), 32'(0));
    check("len0_fifo_rd",    32'(rd_cnt - rd0), 32'(0));

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset in the middle of bit 7 of the first word.
    clear_stats();
    push_word(16'h4489);
    push_word(16'h5555);
    for (int b = 15; b >= 0; b--) exp_bits.push_back(1'(16'h4489 >> b));
    for (int b = 15; b >= 0; b--) exp_bits.push_back(1'(16'h5555 >> b));
    tick();
    len   = 14'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (strobe_cnt < 8 && k < 8 * BC + 20) begin
      tick();
      k++;
    end
    check("midrst_reached_bit7", 32'(strobe_cnt), 32'(8));
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_bits.delete();
    cur_valid = 1'b0;
    check("midrst_busy",       32'(busy),       32'(0));
    check("midrst_bit_out",    32'(bit_out),    32'(0));
    check("midrst_fifo_rd",    32'(fifo_rd),    32'(0));
    check("midrst_bit_strobe", 32'(bit_strobe), 32'(0));
    check("midrst_done",       32'(done),       32'(0));
    tick();
    check("midrst_busy_hold",  32'(busy),       32'(0));
    flush_fifo();

    // After the reset, a one-word transfer behaves as from power-up.
    pv = '{1, 1, 16'hC001, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 0, 0};
    run_vec(pv, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached before the test sequence ended");
    $fatal(1, "watchdog expired");
  end

endmodule
